bp_nonsynth_if_monitor: RTL and testbench

- Non-synthesizable, parametrised runtime protocol monitor for N independent valid/ready channels, such as FE-BE queues, LCE-CCE req/cmd/resp and CCE-mem.
- Extends the team's elaboration-time interface checks to cycle-level checking:
  - handshake rule violations;
  - payload stability while a transfer is pending;
  - stall timeouts;
  - per-channel transaction counts.
- Instantiated passively beside the DUT in testbenches. It drives nothing back into the design.

---
 rtl/bp_nonsynth_if_pkg.sv | 27 ++
 rtl/bp_nonsynth_if_channel_monitor.sv | 152 +++++++++++++++
 rtl/bp_nonsynth_if_monitor.sv | 99 +++++++++
 tb/tb_bp_nonsynth_if_monitor.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_nonsynth_if_pkg.sv
`default_nettype none
// ============================================================================
// bp_nonsynth_if_pkg -- shared types for the valid/ready interface monitor.
// Revision: 1.0
// ============================================================================
package bp_nonsynth_if_pkg;

    typedef enum logic [1:0] {
        e_if_err_none     = 2'd0,
        e_if_err_protocol = 2'd1,
        e_if_err_data     = 2'd2,
        e_if_err_timeout  = 2'd3
    } bp_if_err_e;

    typedef enum logic {
        e_if_valid_ready      = 1'b0,
        e_if_ready_then_valid = 1'b1
    } bp_if_mode_e;

    typedef enum logic [1:0] {
        e_if_idle    = 2'd0,
        e_if_pending = 2'd1,
        e_if_err     = 2'd2
    } bp_if_mon_state_e;

endpackage
`default_nettype wire

// File: rtl/bp_nonsynth_if_channel_monitor.sv
`default_nettype none
// ============================================================================
// bp_nonsynth_if_channel_monitor -- FSM, payload capture, stall and txn count for one channel.
// Revision: 1.0
// ============================================================================
module bp_nonsynth_if_channel_monitor
    import bp_nonsynth_if_pkg::*;
#(
    parameter int width_p         = 64,
    parameter int mode_p          = 0,
    parameter int timeout_p       = 1024,
    parameter int count_width_p   = 32,
    parameter int halt_on_error_p = 0,
    parameter int chan_id_p       = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     en_i,
    input  logic                     v_i,
    input  logic                     ready_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     err_o,
    output logic [1:0]               err_code_o,
    output logic [count_width_p-1:0] txn_count_o,
    output logic                     idle_o,
    output logic                     err_set_o
);

    localparam bp_if_mode_e MODE = (mode_p == 1) ? e_if_ready_then_valid : e_if_valid_ready;
    localparam int STALL_W = $clog2(timeout_p + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(timeout_p);
    localparam logic [count_width_p-1:0] TXN_MAX = '1;

    bp_if_mon_state_e         state_q, state_d;
    bp_if_err_e               code_q, code_d;
    logic [width_p-1:0]       data_q, data_d;
    logic [STALL_W-1:0]       stall_q, stall_d;
    logic [count_width_p-1:0] txn_q, txn_d;

    logic               handshake;
    logic               stall;
    logic               stall_hit;
    logic [STALL_W-1:0] stall_next;
    bp_if_err_e         detect;

    assign handshake = v_i & ready_i;
    assign stall     = v_i & ~ready_i;

    // A fresh stall counts as cycle 1; a continuing one extends the count up to the limit.
    always_comb begin
        stall_next = STALL_W'(1);
        if (state_q == e_if_pending) begin
            stall_next = (stall_q == STALL_MAX) ? STALL_MAX : stall_q + 1'b1;
        end
    end

    assign stall_hit = (stall_next == STALL_MAX);

    always_comb begin
        detect = e_if_err_none;
        if (state_q != e_if_err) begin
            if (MODE == e_if_ready_then_valid) begin
                if (stall) begin
                    detect = e_if_err_protocol;
                end
            end else if (state_q == e_if_pending) begin
                if (!v_i) begin
                    detect = e_if_err_protocol;
                end else if (data_i != data_q) begin
                    detect = e_if_err_data;
                end else if (stall && stall_hit) begin
                    detect = e_if_err_timeout;
                end
            end else if (stall && stall_hit) begin
                detect = e_if_err_timeout;
            end
        end
    end

    assign err_set_o = en_i & (detect != e_if_err_none);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        data_d  = data_q;
        stall_d = stall_q;
        txn_d   = txn_q;
        if (en_i) begin
            if (handshake && (txn_q != TXN_MAX)) begin
                txn_d = txn_q + 1'b1;
            end
            if (detect != e_if_err_none) begin
                state_d = e_if_err;
                code_d  = detect;
            end else begin
                case (state_q)
                    e_if_idle: begin
                        if ((MODE == e_if_valid_ready) && stall) begin
                            state_d = e_if_pending;
                            data_d  = data_i;
                            stall_d = stall_next;
                        end
                    end
                    e_if_pending: begin
                        if (handshake) begin
                            state_d = e_if_idle;
                            stall_d = '0;
                        end else if (stall) begin
                            stall_d = stall_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_if_idle;
            code_q  <= e_if_err_none;
            data_q  <= '0;
            stall_q <= '0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            data_q  <= data_d;
            stall_q <= stall_d;
            txn_q   <= txn_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && err_set_o) begin
            if (halt_on_error_p != 0) begin
                $fatal(1, "[%0t] if_monitor ch%0d halted: code %0d captured=%h current=%h",
                       $time, chan_id_p, detect, data_q, data_i);
            end else begin
                $display("[%0t] if_monitor ch%0d flagged code %0d captured=%h current=%h",
                         $time, chan_id_p, detect, data_q, data_i);
            end
        end
    end

    assign err_o       = (state_q == e_if_err);
    assign err_code_o  = code_q;
    assign txn_count_o = txn_q;
    assign idle_o      = (state_q != e_if_pending);

endmodule
`default_nettype wire

// File: rtl/bp_nonsynth_if_monitor.sv
`default_nettype none
// ============================================================================
// bp_nonsynth_if_monitor -- passive cycle-level checker for N valid/ready channels.
// Revision: 1.0
// ============================================================================
module bp_nonsynth_if_monitor
    import bp_nonsynth_if_pkg::*;
#(
    parameter int num_channels_p  = 4,
    parameter int width_p         = 64,
    parameter int mode_p          = 0,
    parameter int timeout_p       = 1024,
    parameter int count_width_p   = 32,
    parameter int halt_on_error_p = 0,
    localparam int ID_W = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    en_i,
    input  logic [num_channels_p-1:0]               v_i,
    input  logic [num_channels_p-1:0]               ready_i,
    input  logic [num_channels_p*width_p-1:0]       data_i,
    output logic [num_channels_p-1:0]               err_o,
    output logic [2*num_channels_p-1:0]             err_code_o,
    output logic [num_channels_p*count_width_p-1:0] txn_count_o,
    output logic                                    first_err_v_o,
    output logic [ID_W-1:0]                         first_err_id_o,
    output logic                                    all_idle_o
);

    if (num_channels_p < 1) begin : g_check_channels
        $fatal(1, "bp_nonsynth_if_monitor: num_channels_p must be at least 1");
    end
    if (timeout_p < 1) begin : g_check_timeout
        $fatal(1, "bp_nonsynth_if_monitor: timeout_p must be at least 1");
    end
    if ((mode_p != int'(e_if_valid_ready)) && (mode_p != int'(e_if_ready_then_valid))) begin : g_check_mode
        $fatal(1, "bp_nonsynth_if_monitor: mode_p must be 0 or 1");
    end

    logic [num_channels_p-1:0] err_set;
    logic [num_channels_p-1:0] chan_idle;

    for (genvar k = 0; k < num_channels_p; k++) begin : g_chan
        bp_nonsynth_if_channel_monitor #(
            .width_p         (width_p),
            .mode_p          (mode_p),
            .timeout_p       (timeout_p),
            .count_width_p   (count_width_p),
            .halt_on_error_p (halt_on_error_p),
            .chan_id_p       (k)
        ) u_chan (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .en_i        (en_i),
            .v_i         (v_i[k]),
            .ready_i     (ready_i[k]),
            .data_i      (data_i[k*width_p +: width_p]),
            .err_o       (err_o[k]),
            .err_code_o  (err_code_o[2*k +: 2]),
            .txn_count_o (txn_count_o[k*count_width_p +: count_width_p]),
            .idle_o      (chan_idle[k]),
            .err_set_o   (err_set[k])
        );
    end

    logic            first_v_q, first_v_d;
    logic [ID_W-1:0] first_id_q, first_id_d;

    // Scan high-to-low so the lowest simultaneous erroring channel is the one kept.
    always_comb begin
        first_v_d  = first_v_q;
        first_id_d = first_id_q;
        if (!first_v_q) begin
            for (int k = num_channels_p - 1; k >= 0; k--) begin
                if (err_set[k]) begin
                    first_v_d  = 1'b1;
                    first_id_d = ID_W'(k);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            first_v_q  <= 1'b0;
            first_id_q <= '0;
        end else begin
            first_v_q  <= first_v_d;
            first_id_q <= first_id_d;
        end
    end

    assign first_err_v_o  = first_v_q;
    assign first_err_id_o = first_id_q;
    assign all_idle_o     = &chan_idle;

endmodule
`default_nettype wire

// File: tb/tb_bp_nonsynth_if_monitor.sv
`default_nettype none
// ============================================================================
// tb_bp_nonsynth_if_monitor -- directed scenarios plus randomized run against a rule-level model.
// Revision: 1.0
// ============================================================================
module tb_bp_nonsynth_if_monitor;

    localparam int NA  = 4;
    localparam int WA  = 16;
    localparam int CWA = 8;
    localparam int TOA = 4;
    localparam int NB  = 2;
    localparam int WB  = 8;
    localparam int CWB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en_a, en_b;

    logic [NA-1:0]     v_a, r_a;
    logic [NA*WA-1:0]  d_a;
    logic [NA-1:0]     err_a;
    logic [2*NA-1:0]   code_a;
    logic [NA*CWA-1:0] txn_a;
    logic              fev_a;
    logic [1:0]        fid_a;
    logic              idle_a;

    logic [NB-1:0]     v_b, r_b;
    logic [NB*WB-1:0]  d_b;
    logic [NB-1:0]     err_b;
    logic [2*NB-1:0]   code_b;
    logic [NB*CWB-1:0] txn_b;
    logic              fev_b;
    logic [0:0]        fid_b;
    logic              idle_b;

    int n_cmp;
    int n_fail;

    bp_nonsynth_if_monitor #(
        .num_channels_p(NA), .width_p(WA), .mode_p(0), .timeout_p(TOA),
        .count_width_p(CWA), .halt_on_error_p(0)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en_a), .v_i(v_a), .ready_i(r_a), .data_i(d_a),
        .err_o(err_a), .err_code_o(code_a), .txn_count_o(txn_a), .first_err_v_o(fev_a),
        .first_err_id_o(fid_a), .all_idle_o(idle_a)
    );

    bp_nonsynth_if_monitor #(
        .num_channels_p(NB), .width_p(WB), .mode_p(1), .timeout_p(TOA),
        .count_width_p(CWB), .halt_on_error_p(0)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en_b), .v_i(v_b), .ready_i(r_b), .data_i(d_b),
        .err_o(err_b), .err_code_o(code_b), .txn_count_o(txn_b), .first_err_v_o(fev_b),
        .first_err_id_o(fid_b), .all_idle_o(idle_b)
    );

    // Rule-level reference for dut_a: a stall is a wait that began with an unanswered valid.
    bit              m_pend[NA];
    int              m_wait[NA];
    int              m_code[NA];
    int              m_cnt[NA];
    logic [WA-1:0]   m_cap[NA];
    bit              m_fv;
    int              m_fid;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_fv  = 1'b0;
            m_fid = 0;
            for (int k = 0; k < NA; k++) begin
                m_pend[k] = 1'b0; m_wait[k] = 0; m_code[k] = 0; m_cnt[k] = 0; m_cap[k] = '0;
            end
        end else if (en_a) begin
            for (int k = 0; k < NA; k++) begin
                automatic bit            v = v_a[k];
                automatic bit            r = r_a[k];
                automatic logic [WA-1:0] d = d_a[k*WA +: WA];
                automatic int            c = 0;
                if (v && r && m_cnt[k] < (1 << CWA) - 1) m_cnt[k]++;
                if (m_code[k] == 0) begin
                    if (m_pend[k] && !v) c = 1;
                    else if (m_pend[k] && d !== m_cap[k]) c = 2;
                    else if (v && !r && (m_pend[k] ? m_wait[k] + 1 : 1) >= TOA) c = 3;
                    if (c != 0) begin
                        m_code[k] = c;
                        m_pend[k] = 1'b0;
                        if (!m_fv) begin m_fv = 1'b1; m_fid = k; end
                    end else if (v && !r) begin
                        if (!m_pend[k]) begin m_cap[k] = d; m_wait[k] = 1; end
                        else m_wait[k]++;
                        m_pend[k] = 1'b1;
                    end else if (v && r) begin
                        m_pend[k] = 1'b0;
                        m_wait[k] = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1;
        v_a = '0; r_a = '0; d_a = '0;
        v_b = '0; r_b = '0; d_b = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        v_a = '1; r_a = '0; d_a = '1;
        rst_n = 1'b0;
        tick();
        n_cmp++; if (err_a !== 4'b0)   begin n_fail++; $display("FAIL reset_err: got %b want 0000", err_a); end
        n_cmp++; if (code_a !== 8'h0)  begin n_fail++; $display("FAIL reset_code: got %h want 00", code_a); end
        n_cmp++; if (txn_a !== 32'h0)  begin n_fail++; $display("FAIL reset_txn: got %h want 0", txn_a); end
        n_cmp++; if (fev_a !== 1'b0)   begin n_fail++; $display("FAIL reset_fev: got %b want 0", fev_a); end
        n_cmp++; if (fid_a !== 2'd0)   begin n_fail++; $display("FAIL reset_fid: got %0d want 0", fid_a); end
        n_cmp++; if (idle_a !== 1'b1)  begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle_a); end
        do_reset();
    endtask

    task automatic test_handshake();
        do_reset();
        d_a[15:0] = 16'h00A5; v_a[0] = 1'b1; r_a[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (idle_a !== 1'b0) begin n_fail++; $display("FAIL hs_idle_stall cyc %0d: got %b want 0", i, idle_a); end
        end
        r_a[0] = 1'b1;
        tick();
        n_cmp++; if (idle_a !== 1'b1)        begin n_fail++; $display("FAIL hs_idle_done: got %b want 1", idle_a); end
        n_cmp++; if (txn_a[7:0] !== 8'd1)    begin n_fail++; $display("FAIL hs_txn0: got %0d want 1", txn_a[7:0]); end
        n_cmp++; if (err_a !== 4'b0)         begin n_fail++; $display("FAIL hs_err: got %b want 0000", err_a); end
        v_a = '0; r_a = '0;
        tick();
    endtask

    task automatic test_protocol();
        do_reset();
        d_a[31:16] = 16'h0010; v_a[1] = 1'b1;
        tick();
        n_cmp++; if (err_a !== 4'b0) begin n_fail++; $display("FAIL proto_pre_err: got %b want 0000", err_a); end
        v_a[1] = 1'b0;
        tick();
        n_cmp++; if (err_a !== 4'b0010)      begin n_fail++; $display("FAIL proto_err: got %b want 0010", err_a); end
        n_cmp++; if (code_a[3:2] !== 2'd1)   begin n_fail++; $display("FAIL proto_code1: got %0d want 1", code_a[3:2]); end
        n_cmp++; if (fev_a !== 1'b1)         begin n_fail++; $display("FAIL proto_fev: got %b want 1", fev_a); end
        n_cmp++; if (fid_a !== 2'd1)         begin n_fail++; $display("FAIL proto_fid: got %0d want 1", fid_a); end
        v_a[1] = 1'b1; r_a[1] = 1'b1;
        tick(); tick();
        v_a[1] = 1'b1; r_a[1] = 1'b0;
        tick();
        n_cmp++; if (txn_a[15:8] !== 8'd2)   begin n_fail++; $display("FAIL proto_txn1_after_err: got %0d want 2", txn_a[15:8]); end
        n_cmp++; if (code_a[3:2] !== 2'd1)   begin n_fail++; $display("FAIL proto_code_sticky: got %0d want 1", code_a[3:2]); end
        v_a = '0; r_a = '0;
    endtask

    task automatic test_data_change();
        do_reset();
        d_a[47:32] = 16'h0010; v_a[2] = 1'b1;
        tick();
        d_a[47:32] = 16'h0011;
        tick();
        n_cmp++; if (code_a[5:4] !== 2'd2)   begin n_fail++; $display("FAIL data_code2: got %0d want 2", code_a[5:4]); end
        n_cmp++; if (fid_a !== 2'd2)         begin n_fail++; $display("FAIL data_fid: got %0d want 2", fid_a); end
        do_reset();
        d_a[47:32] = 16'h0010; d_a[63:48] = 16'h0010; v_a[3:2] = 2'b11;
        tick();
        v_a[2] = 1'b0; d_a[63:48] = 16'h0011;
        tick();
        n_cmp++; if (fid_a !== 2'd2)         begin n_fail++; $display("FAIL simul_fid: got %0d want 2", fid_a); end
        n_cmp++; if (code_a !== 8'b1001_0000) begin n_fail++; $display("FAIL simul_codes: got %b want 10010000", code_a); end
        n_cmp++; if (err_a !== 4'b1100)      begin n_fail++; $display("FAIL simul_err: got %b want 1100", err_a); end
        v_a = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        d_a[15:0] = 16'h1234; v_a[0] = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (err_a !== 4'b0)         begin n_fail++; $display("FAIL tmo_early: got %b want 0000", err_a); end
        tick();
        n_cmp++; if (err_a !== 4'b0001)      begin n_fail++; $display("FAIL tmo_err: got %b want 0001", err_a); end
        n_cmp++; if (code_a[1:0] !== 2'd3)   begin n_fail++; $display("FAIL tmo_code0: got %0d want 3", code_a[1:0]); end
        n_cmp++; if (idle_a !== 1'b1)        begin n_fail++; $display("FAIL tmo_idle: got %b want 1", idle_a); end
        do_reset();
        d_a[15:0] = 16'h1234; v_a[0] = 1'b1;
        tick(); tick();
        en_a = 1'b0;
        v_a[1] = 1'b1; r_a[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_a[15:0] = 16'($urandom);
            tick();
        end
        n_cmp++; if (err_a !== 4'b0)         begin n_fail++; $display("FAIL en_hold_err: got %b want 0000", err_a); end
        n_cmp++; if (txn_a[15:8] !== 8'd0)   begin n_fail++; $display("FAIL en_hold_txn1: got %0d want 0", txn_a[15:8]); end
        n_cmp++; if (idle_a !== 1'b0)        begin n_fail++; $display("FAIL en_hold_idle: got %b want 0", idle_a); end
        en_a = 1'b1; v_a[1] = 1'b0; r_a[1] = 1'b0; d_a[15:0] = 16'h1234;
        tick();
        r_a[0] = 1'b1;
        tick();
        n_cmp++; if (err_a !== 4'b0)         begin n_fail++; $display("FAIL en_resume_err: got %b want 0000", err_a); end
        n_cmp++; if (txn_a[7:0] !== 8'd1)    begin n_fail++; $display("FAIL en_resume_txn0: got %0d want 1", txn_a[7:0]); end
        v_a = '0; r_a = '0;
    endtask

    task automatic test_mode1();
        do_reset();
        v_b = 2'b11; r_b = 2'b10; d_b = 16'hBEEF;
        tick();
        n_cmp++; if (err_b !== 2'b01)        begin n_fail++; $display("FAIL m1_err: got %b want 01", err_b); end
        n_cmp++; if (code_b[1:0] !== 2'd1)   begin n_fail++; $display("FAIL m1_code0: got %0d want 1", code_b[1:0]); end
        n_cmp++; if (fid_b !== 1'b0 || fev_b !== 1'b1) begin n_fail++; $display("FAIL m1_first: got v=%b id=%0d want v=1 id=0", fev_b, fid_b); end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (txn_b[3:2] !== 2'd3)    begin n_fail++; $display("FAIL m1_txn_sat: got %0d want 3", txn_b[3:2]); end
        n_cmp++; if (err_b[1] !== 1'b0)      begin n_fail++; $display("FAIL m1_err1: got %b want 0", err_b[1]); end
        n_cmp++; if (idle_b !== 1'b1)        begin n_fail++; $display("FAIL m1_idle: got %b want 1", idle_b); end
        v_b = '0; r_b = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_a = 64'h0000_0000_0042_0000; v_a[1] = 1'b1; v_a[3] = 1'b1; r_a[3] = 1'b1;
        tick();
        v_a[1] = 1'b0; v_a[3] = 1'b0; r_a[3] = 1'b0; v_a[2] = 1'b1;
        tick();
        n_cmp++; if (err_a[1] !== 1'b1)      begin n_fail++; $display("FAIL rmid_pre_err1: got %b want 1", err_a[1]); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if (err_a !== 4'b0)         begin n_fail++; $display("FAIL rmid_err: got %b want 0000", err_a); end
        n_cmp++; if (code_a !== 8'h0)        begin n_fail++; $display("FAIL rmid_code: got %h want 00", code_a); end
        n_cmp++; if (txn_a !== 32'h0)        begin n_fail++; $display("FAIL rmid_txn: got %h want 0", txn_a); end
        n_cmp++; if (fev_a !== 1'b0 || fid_a !== 2'd0) begin n_fail++; $display("FAIL rmid_first: got v=%b id=%0d want v=0 id=0", fev_a, fid_a); end
        n_cmp++; if (idle_a !== 1'b1)        begin n_fail++; $display("FAIL rmid_idle: got %b want 1", idle_a); end
        rst_n = 1'b1; v_a = '0; r_a = '0;
        tick();
        v_a[1] = 1'b1; r_a[1] = 1'b1;
        tick();
        v_a = '0; r_a = '0;
        tick();
        n_cmp++; if (err_a !== 4'b0 || fev_a !== 1'b0) begin n_fail++; $display("FAIL rmid_clean_err: got %b/%b want 0000/0", err_a, fev_a); end
        n_cmp++; if (txn_a[15:8] !== 8'd1)   begin n_fail++; $display("FAIL rmid_clean_txn1: got %0d want 1", txn_a[15:8]); end
    endtask

    task automatic test_random();
        logic [NA-1:0]     exp_err;
        logic [2*NA-1:0]   exp_code;
        logic [NA*CWA-1:0] exp_txn;
        logic              exp_idle;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            en_a  = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < NA; k++) begin
                if (m_pend[k]) begin
                    v_a[k] = ($urandom_range(0, 19) != 0);
                    if ($urandom_range(0, 19) == 0) d_a[k*WA +: WA] = 16'($urandom);
                end else begin
                    v_a[k] = 1'($urandom_range(0, 1));
                    d_a[k*WA +: WA] = 16'($urandom);
                end
                r_a[k] = 1'($urandom_range(0, 1));
            end
            tick();
            exp_idle = 1'b1;
            for (int k = 0; k < NA; k++) begin
                exp_err[k]              = (m_code[k] != 0);
                exp_code[2*k +: 2]      = 2'(m_code[k]);
                exp_txn[k*CWA +: CWA]   = CWA'(m_cnt[k]);
                if (m_pend[k]) exp_idle = 1'b0;
            end
            n_cmp++; if (err_a !== exp_err)   begin n_fail++; $display("FAIL rand_err cyc %0d: got %b want %b", cyc, err_a, exp_err); end
            n_cmp++; if (code_a !== exp_code) begin n_fail++; $display("FAIL rand_code cyc %0d: got %b want %b", cyc, code_a, exp_code); end
            n_cmp++; if (txn_a !== exp_txn)   begin n_fail++; $display("FAIL rand_txn cyc %0d: got %h want %h", cyc, txn_a, exp_txn); end
            n_cmp++; if (idle_a !== exp_idle) begin n_fail++; $display("FAIL rand_idle cyc %0d: got %b want %b", cyc, idle_a, exp_idle); end
            n_cmp++; if (fev_a !== m_fv)      begin n_fail++; $display("FAIL rand_fev cyc %0d: got %b want %b", cyc, fev_a, m_fv); end
            n_cmp++; if (fid_a !== 2'(m_fid)) begin n_fail++; $display("FAIL rand_fid cyc %0d: got %0d want %0d", cyc, fid_a, m_fid); end
        end
        rst_n = 1'b1; en_a = 1'b1; v_a = '0; r_a = '0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0; en_a = 1'b1; en_b = 1'b1;
        v_a = '0; r_a = '0; d_a = '0;
        v_b = '0; r_b = '0; d_b = '0;
        test_reset();
        test_handshake();
        test_protocol();
        test_data_change();
        test_timeout();
        test_mode1();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
